// File: rtl/edge_event_arb.sv
// Edge-event controller: per-channel edge detect, pending/loss tracking and a
// round-robin arbiter offering one event at a time on a valid/ready port.
module edge_event_arb #(
    parameter int NCH       = 4,
    parameter int IDW       = 2,
    parameter int EDGE_MODE = 0
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [NCH-1:0] cin,
    output logic           evt_valid,
    output logic [IDW-1:0] evt_id,
    input  logic           evt_ready,
    output logic [NCH-1:0] evt_lost,
    input  logic           lost_clr
);
    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [NCH-1:0] cin_q;
    logic           armed_q;
    logic [NCH-1:0] pending_q, pending_d;
    logic [NCH-1:0] lost_q, lost_d;
    logic [IDW-1:0] evt_id_q, evt_id_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic [NCH-1:0] edge_det, xfer_vec, lost_set;
    logic [IDW-1:0] rr_pick, rr_idx;
    logic           rr_found;
    logic           xfer;

    assign xfer = (state_q == OFFER) && evt_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            // Nothing is detected until the first post-reset edge has captured cin_q.
            assign edge_det[gi] = armed_q & ((EDGE_MODE == 0) ? (cin[gi] & ~cin_q[gi]) :
                                             (EDGE_MODE == 1) ? (~cin[gi] & cin_q[gi]) :
                                                                (cin[gi] ^ cin_q[gi]));
            assign xfer_vec[gi] = xfer && (evt_id_q == IDW'(gi));
        end
    endgenerate

    // A new edge coinciding with its own transfer is a fresh event, not a loss.
    assign lost_set  = edge_det & pending_q & ~xfer_vec;
    assign pending_d = (pending_q & ~xfer_vec) | edge_det;
    assign lost_d    = (lost_clr ? '0 : lost_q) | lost_set;

    always_comb begin
        rr_pick  = '0;
        rr_found = 1'b0;
        rr_idx   = last_grant_q;
        for (int k = 0; k < NCH; k++) begin
            rr_idx = (rr_idx == IDW'(NCH - 1)) ? '0 : rr_idx + IDW'(1);
            if (!rr_found && pending_q[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        evt_id_d     = evt_id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    evt_id_d = rr_pick;
                    state_d  = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    last_grant_d = evt_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cin_q        <= '0;
            armed_q      <= 1'b0;
            pending_q    <= '0;
            lost_q       <= '0;
            evt_id_q     <= '0;
            last_grant_q <= IDW'(NCH - 1);
        end else begin
            state_q      <= state_d;
            cin_q        <= cin;
            armed_q      <= 1'b1;
            pending_q    <= pending_d;
            lost_q       <= lost_d;
            evt_id_q     <= evt_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign evt_valid = (state_q == OFFER);
    assign evt_id    = evt_id_q;
    assign evt_lost  = lost_q;
endmodule
